// File: rtl/dly_sched_pkg.sv
// ----------------------------------------------------------------------------
// dly_sched_pkg
// Shared definitions for the delay-table command scheduler:
//   - state_t        : scheduler FSM state encoding (also exported on O_state)
//   - AWG_LSB        : LSB of the 4-bit AWG ID field in the 64-bit frame
//   - PORT_LSB       : LSB of the 4-bit DAC port field in the 64-bit frame
//   - DELAY_W        : width of the delay field (frame bits [23:0])
//   - DEFAULT_CMD_HEADER : delay-RAM write opcode placed in frame bits [63:32]
// ----------------------------------------------------------------------------
package dly_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   localparam int unsigned AWG_LSB  = 28;
   localparam int unsigned PORT_LSB = 24;
   localparam int unsigned DELAY_W  = 24;

   localparam logic [31:0] DEFAULT_CMD_HEADER = 32'h0200_2000;

endpackage

// File: rtl/dly_rr_arbiter.sv
// ----------------------------------------------------------------------------
// dly_rr_arbiter
// Purely combinational round-robin pick. Returns the first set request bit
// at or after the pointer, wrapping past N_REQ-1 back to 0.
// Ports:
//   req_i   [N_REQ-1:0] request vector
//   ptr_i   [PTR_W-1:0] highest-priority index (pointer register lives in the top)
//   grant_o [PTR_W-1:0] chosen index (0 when valid_o is low)
//   valid_o             at least one request is set
// ----------------------------------------------------------------------------
module dly_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [PTR_W-1:0] grant_o,
   output logic             valid_o
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      // Scan from the farthest offset back toward the pointer so the set bit
      // nearest the pointer is the last one written and therefore wins.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         idx = PTR_W'((32'(ptr_i) + 32'(off)) % N_REQ);
         if (req_i[idx]) begin
            grant_o = idx;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/delay_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// delay_cmd_scheduler
// Shares one UART_TX_DATA 64-bit frame sender between N_REQ delay-table
// writers (one per AWG DAC port). Requests are granted round-robin, the frame
// {CMD_HEADER, awg_id[3:0], port[3:0], delay[23:0]} is latched at grant, the
// sender's data-valid is pulsed, and the sender's tx_ready is tracked until
// the frame has been shifted out, followed by GAP_CYCLES idle cycles.
//
// Handshake: I_req is a level held until O_ack pulses for that port; the
// frame is offered once via a one-cycle O_data_valid while I_tx_ready is high,
// accepted when I_tx_ready falls, and complete when I_tx_ready rises again.
//
// Optional feature macro: DLY_SCHED_TIMEOUT_EN
//   defined   : 16-bit accept/complete timeout, sticky O_err, frame dropped
//   undefined : FSM waits indefinitely, O_err tied 0
//
// Ports:
//   I_clk_10M     10 MHz UART clock
//   I_rst         asynchronous reset, active-high
//   I_req         per-port write request (level)
//   I_awg_id      per-port AWG ID, port k at [4k+3:4k]
//   I_delay       per-port delay, port k at [24k+23:24k]
//   O_ack         one-cycle capture pulse per port
//   O_data        frame to the sender
//   O_data_valid  one-cycle frame strobe to the sender
//   I_tx_ready    sender idle
//   O_busy        FSM not in IDLE
//   O_err         sticky timeout flag
//   O_state       current FSM state (state_t encoding) for observation
// ----------------------------------------------------------------------------
module delay_cmd_scheduler
   import dly_sched_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter logic [31:0] CMD_HEADER     = DEFAULT_CMD_HEADER,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 2048
) (
   input  logic                   I_clk_10M,
   input  logic                   I_rst,
   input  logic [N_REQ-1:0]       I_req,
   input  logic [4*N_REQ-1:0]     I_awg_id,
   input  logic [24*N_REQ-1:0]    I_delay,
   output logic [N_REQ-1:0]       O_ack,
   output logic [63:0]            O_data,
   output logic                   O_data_valid,
   input  logic                   I_tx_ready,
   output logic                   O_busy,
   output logic                   O_err,
   output logic [2:0]             O_state
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [63:0]        data_q, data_d;
   logic               valid_q, valid_d;
   logic [15:0]        gap_q, gap_d;

   logic [PTR_W-1:0]   arb_grant;
   logic               arb_valid;
   logic [3:0]         sel_awg;
   logic [DELAY_W-1:0] sel_delay;

   dly_rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req_i   (I_req),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .valid_o (arb_valid)
   );

   // Field mux for the port the arbiter currently picks.
   always_comb begin
      sel_awg   = '0;
      sel_delay = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (arb_grant == PTR_W'(k)) begin
            sel_awg   = I_awg_id[4*k +: 4];
            sel_delay = I_delay[DELAY_W*k +: DELAY_W];
         end
      end
   end

`ifdef DLY_SCHED_TIMEOUT_EN
   logic [15:0] to_q, to_d;
   logic        err_q, err_d;
   logic        to_hit;

   // Limit is the last count value, so the hit lands TIMEOUT_CYCLES cycles
   // after WAIT_BUSY is entered.
   assign to_hit = (to_q == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      ack_d   = '0;
      data_d  = data_q;
      gap_d   = gap_q;
      // The strobe is registered from ISSUE, so it appears one cycle after
      // O_ack and lasts exactly one cycle.
      valid_d = (state_q == ST_ISSUE);
`ifdef DLY_SCHED_TIMEOUT_EN
      to_d    = to_q;
      err_d   = err_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid && I_tx_ready) begin
               grant_d          = arb_grant;
               ack_d[arb_grant] = 1'b1;
               data_d           = {CMD_HEADER, sel_awg, 4'(32'(arb_grant) + 32'd1), sel_delay};
               state_d          = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            ptr_d   = (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + PTR_W'(1);
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!I_tx_ready) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (I_tx_ready) begin
               gap_d   = 16'(GAP_CYCLES);
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            // A loaded value of 0 or 1 both leave after a single GAP cycle.
            if (gap_q <= 16'd1) state_d = ST_IDLE;
            else                gap_d   = gap_q - 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef DLY_SCHED_TIMEOUT_EN
      if (state_q == ST_ISSUE) to_d = '0;
      if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
         to_d = to_q + 16'd1;
         // Timeout abandons the frame; it is not retried.
         if (to_hit) begin
            err_d   = 1'b1;
            gap_d   = 16'(GAP_CYCLES);
            state_d = ST_GAP;
         end
      end
`endif
   end

   always_ff @(posedge I_clk_10M or posedge I_rst) begin
      if (I_rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         gap_q   <= gap_d;
      end
   end

`ifdef DLY_SCHED_TIMEOUT_EN
   always_ff @(posedge I_clk_10M or posedge I_rst) begin
      if (I_rst) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end

   assign O_err = err_q;
`else
   // No timeout hardware in this build; TIMEOUT_CYCLES is kept so both
   // builds share one parameter list.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
   assign O_err = 1'b0;
`endif

   assign O_ack        = ack_q;
   assign O_data       = data_q;
   assign O_data_valid = valid_q;
   assign O_busy       = (state_q != ST_IDLE);
   assign O_state      = state_q;

endmodule
